// File: rtl/bin2bcd_feeder_pkg.sv
// Shared types and constants for the bin2bcd_feeder converter.
// Holds the FSM state enum, default digit count, step-counter width and saturation digit.
package bin2bcd_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NDIG_DEF = 8;

  // Wide enough to count up to 32 double-dabble steps.
  localparam int CNT_W = 6;

  // Saturated output repeats this digit across every BCD position.
  localparam logic [3:0] SAT_DIGIT = 4'h9;

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step: add 3 to every digit >= 5, then shift left by one.
// Zero latency; purely combinational, so there is no backpressure.
module bcd_dabble_step #(
  parameter int ND = 10
) (
  input  logic [4*ND-1:0] bcd_i,
  input  logic            bit_i,
  output logic [4*ND-1:0] bcd_o
);

  localparam int BW = 4 * ND;

  logic [BW-1:0] corr;

  always_comb begin
    corr = bcd_i;
    for (int k = 0; k < ND; k++) begin
      if (bcd_i[4*k +: 4] >= 4'd5) begin
        corr[4*k +: 4] = bcd_i[4*k +: 4] + 4'd3;
      end
    end
    bcd_o = (corr << 1) | BW'(bit_i);
  end

endmodule

// File: rtl/bin2bcd_feeder.sv
// Serial binary-to-BCD converter, one double-dabble step per cycle; o_cs follows W+2 cycles after accept.
// Accepts only in IDLE (o_ready); optional BCD_SATURATE_EN clamps overflowing results to all nines.
module bin2bcd_feeder
  import bin2bcd_feeder_pkg::*;
#(
  parameter int W    = 32,
  parameter int NDIG = NDIG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [W-1:0]      i_bin,
  output logic              o_ready,
  output logic [4*NDIG-1:0] o_data,
  output logic              o_cs
);

  // Two spare digits so a full 32-bit value never overflows the scratch.
  localparam int SD = NDIG + 2;

  state_t                state_q, state_d;
  logic [W-1:0]          bin_q, bin_d;
  logic [4*SD-1:0]       scr_q, scr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*NDIG-1:0]     data_q, data_d;
  logic                  cs_q, cs_d;
  logic [4*SD-1:0]       step_bcd;
  logic [4*NDIG-1:0]     result;

  bcd_dabble_step #(
    .ND(SD)
  ) u_step (
    .bcd_i(scr_q),
    .bit_i(bin_q[W-1]),
    .bcd_o(step_bcd)
  );

`ifdef BCD_SATURATE_EN
  always_comb begin
    if (|scr_q[4*SD-1:4*NDIG]) begin
      result = {NDIG{SAT_DIGIT}};
    end else begin
      result = scr_q[4*NDIG-1:0];
    end
  end
`else
  assign result = scr_q[4*NDIG-1:0];
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    cs_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          bin_d   = i_bin;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = step_bcd;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        data_d  = result;
        cs_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_data  = data_q;
  assign o_cs    = cs_q;

endmodule

// File: tb/tb_bin2bcd_feeder.sv
// Scoreboard bench for bin2bcd_feeder: directed values, expected BCD and latency queued at accept.
// Build with +define+BCD_SATURATE_EN to check the saturating variant.
module tb_bin2bcd_feeder;

  localparam int W    = 32;
  localparam int NDIG = 8;
  localparam int LAT  = W + 2;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_bin;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_cs;

  int          checks;
  int          errors;
  int          cyc;
  int          last_acc;
  logic [31:0] last_data;
  exp_t        sb[$];

  bin2bcd_feeder #(
    .W(W),
    .NDIG(NDIG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .i_bin(i_bin),
    .o_ready(o_ready),
    .o_data(o_data),
    .o_cs(o_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every o_cs and checks o_data holds otherwise.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst) begin
      last_data = '0;
    end else if (o_cs) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cs: o_cs pulse with nothing pending, o_data=%h", o_data);
      end else begin
        e = sb.pop_front();
        check("result", o_data, e.data);
        check("latency", 32'(cyc - e.acc), 32'(LAT));
      end
      last_data = o_data;
    end else begin
      check("hold", o_data, last_data);
    end
  end

  task automatic send(input logic [31:0] v, input logic [31:0] exp, input bit push);
    bit rdy;
    bit ok;
    @(negedge clk);
    i_valid = 1'b1;
    i_bin   = v;
    ok      = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      rdy = o_ready;
      @(posedge clk);
      if (rdy) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: value %h never accepted", v);
    end else begin
      last_acc = cyc;
      if (push) sb.push_back('{exp, cyc});
    end
  endtask

  task automatic wait_empty(input string name);
    @(negedge clk);
    i_valid = 1'b0;
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
    check({name, "_ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    int acc_a;
    logic [31:0] exp_ff;
    logic [31:0] exp_1e8;
`ifdef BCD_SATURATE_EN
    exp_ff  = 32'h99999999;
    exp_1e8 = 32'h99999999;
`else
    exp_ff  = 32'h94967295;
    exp_1e8 = 32'h00000000;
`endif
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    last_acc  = 0;
    last_data = '0;
    rst       = 1'b0;
    i_valid   = 1'b0;
    i_bin     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_data", o_data, 32'h0);
    check("rst_cs", 32'(o_cs), 32'd0);
    rst = 1'b1;

    send(32'd0, 32'h00000000, 1'b1);
    @(negedge clk);
    check("busy_ready", 32'(o_ready), 32'd0);
    wait_empty("zero");

    send(32'h00BC614E, 32'h12345678, 1'b1);
    wait_empty("d12345678");
    send(32'd99999999, 32'h99999999, 1'b1);
    wait_empty("d99999999");
    send(32'hFFFFFFFF, exp_ff, 1'b1);
    wait_empty("ffffffff");
    send(32'd100000000, exp_1e8, 1'b1);
    wait_empty("d100000000");

    // Value offered during SHIFT must be ignored entirely.
    send(32'd42, 32'h00000042, 1'b1);
    repeat (5) @(negedge clk);
    i_valid = 1'b1;
    i_bin   = 32'd7;
    repeat (10) @(negedge clk);
    wait_empty("ignore");

    // Held i_valid: second value taken on the edge after DONE->IDLE.
    send(32'd123, 32'h00000123, 1'b1);
    acc_a = last_acc;
    send(32'd9876, 32'h00009876, 1'b1);
    check("b2b_gap", 32'(last_acc - acc_a), 32'(LAT));
    wait_empty("b2b");

    send(32'd55, 32'h00000055, 1'b1);
    wait_empty("d55");
    check("d55_data", o_data, 32'h00000055);
    send(32'h00BC614E, 32'h0, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_data", o_data, 32'h0);
    check("abort_cs", 32'(o_cs), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_ready", 32'(o_ready), 32'd1);
    check("post_rst_data", o_data, 32'h0);

    send(32'd1000, 32'h00001000, 1'b1);
    wait_empty("resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_feeder.md
BIN2BCD_FEEDER -- requirements
Module: bin2bcd_feeder

Interface
REQ-001 SHALL have parameter W, default 32: width of the binary input, range 1..32.
REQ-002 SHALL have parameter NDIG, default 8: number of packed BCD output digits.
REQ-003 SHALL have port clk  input  1: single clock; all state on the rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  1: the binary value is offered.
REQ-006 SHALL have port i_bin  input  W: unsigned binary value to convert.
REQ-007 SHALL have port o_ready  output  1: idle and able to accept a value.
REQ-008 SHALL have port o_data  output  4*NDIG: packed BCD; digit 0 is in bits [3:0].
REQ-009 SHALL have port o_cs  output  1: one-cycle strobe marking o_data valid and newly updated.

Function
REQ-010 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-011 SHALL assert o_ready only in IDLE.
REQ-012 IDLE: on a clock edge with i_valid=1, SHALL capture i_bin, clear the BCD scratch and the iteration counter, and go to SHIFT.
REQ-013 SHIFT: SHALL perform one double-dabble step per cycle, MSB first: add 3 to each scratch digit >= 5, then shift left by 1.
REQ-014 SHALL keep the scratch register at NDIG+2 digits internally, so no intermediate overflow occurs for W=32.
REQ-015 SHALL leave SHIFT after exactly W steps and go to DONE.
REQ-016 DONE: SHALL load o_data with the final result and assert o_cs for exactly one cycle, then return to IDLE.
REQ-017 Latency: o_cs SHALL be high in the (W+2)th cycle after the accept edge, i.e. 34 cycles for W=32.
REQ-018 Throughput: SHALL accept the next value no earlier than the edge after DONE.
REQ-019 SHALL ignore i_valid outside IDLE: no queueing, and the in-flight value is unaffected.
REQ-020 SHALL change o_data only in DONE; between conversions o_data holds the last result.
REQ-021 Simultaneous events: on the DONE→IDLE edge i_valid is not sampled; a value is accepted on the following edge.
REQ-022 Input zero SHALL still take the full W steps and SHALL yield all-zero digits.

Reset
REQ-023 On rst=0, asynchronously: state=IDLE, o_ready=1, o_data=0, o_cs=0, scratch and counter cleared.
REQ-024 Reset asserted mid-conversion SHALL abort it with no o_cs pulse and no o_data update.
REQ-025 Operation SHALL resume from IDLE on the first clock edge after rst is released.

Configuration
REQ-026 Macro BCD_SATURATE_EN defined: if the converted value exceeds 10^NDIG-1, o_data SHALL be all digits 9 (0x99999999 for NDIG=8).
REQ-027 Macro BCD_SATURATE_EN undefined: o_data SHALL be the low NDIG digits, i.e. value mod 10^NDIG.
REQ-028 Neither setting SHALL change latency or handshake timing.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the default NDIG, the step-counter width constant and the saturation pattern constant.
REQ-030 One combinational sub-module, bcd_dabble_step, SHALL perform the per-step add-3 correction and shift over all scratch digits; it SHALL be instantiated once.

Verification
REQ-031 Reset release, i_bin=0, i_valid pulse: o_ready drops, o_cs pulses at cycle 34, o_data=0x00000000, o_ready returns high.
REQ-032 i_bin=0x00BC614E (12345678): o_data=0x12345678 with a single o_cs pulse.
REQ-033 i_bin=99999999 gives 0x99999999. i_bin=0xFFFFFFFF gives 0x99999999 with BCD_SATURATE_EN, and 0x94967295 without it.
REQ-034 i_bin=100000000 gives 0x99999999 with BCD_SATURATE_EN, and 0x00000000 without it.
REQ-035 Convert 42; during SHIFT drive i_valid=1 with i_bin=7: result is 0x00000042 with exactly one o_cs pulse, and 7 is not converted.
REQ-036 Convert 55 (o_data=0x00000055), then start 12345678 and assert rst at cycle 10: no o_cs pulse, o_data=0, o_ready=1 after release.
